// File: rtl/rst_seq_ctrl.sv
// Multi-domain reset sequencer. When a sequence starts, every masked domain reset
// is asserted and held. The domains are then released one at a time, lowest index
// first. After each release the block waits for that domain's ack (bounded by a
// timeout) and a guard gap before it releases the next domain. Block reset loads
// the HOLD state with all domains masked, so a full sequence runs out of reset.
module rst_seq_ctrl #(
  parameter int C_NUM_RST     = 4,
  parameter int C_HOLD_CLKS   = 50,
  parameter int C_GAP_CLKS    = 16,
  parameter int C_ACK_TIMEOUT = 1024,
  parameter int C_CNT_W       = 16
) (
  input  logic                 SYS_CLK_I,
  input  logic                 SYS_RST_I,
  input  logic                 REQ_I,
  input  logic [C_NUM_RST-1:0] MASK_I,
  input  logic [C_NUM_RST-1:0] ACK_I,
  output logic [C_NUM_RST-1:0] RST_O,
  output logic                 BUSY_O,
  output logic                 DONE_O,
  output logic [C_NUM_RST-1:0] ERR_O
);

  localparam int IDX_W = (C_NUM_RST > 1) ? $clog2(C_NUM_RST) : 1;
  localparam logic [C_CNT_W-1:0] HOLD_L = C_CNT_W'(C_HOLD_CLKS);
  localparam logic [C_CNT_W-1:0] GAP_L  = C_CNT_W'(C_GAP_CLKS);
  localparam logic [C_CNT_W-1:0] TO_L   = C_CNT_W'(C_ACK_TIMEOUT);
  localparam logic [C_CNT_W-1:0] ONE    = C_CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RELEASE, S_WAIT_ACK, S_GAP, S_DONE
  } state_t;

  state_t               state_q, state_d, after_dom;
  logic [C_CNT_W-1:0]   cnt_q;
  logic [C_NUM_RST-1:0] rem_q;    // masked domains not yet released
  logic [C_NUM_RST-1:0] rst_q;
  logic [C_NUM_RST-1:0] err_q;
  logic [IDX_W-1:0]     idx_q;    // domain currently being released / waited on
  logic [IDX_W-1:0]     nxt_idx;
  logic                 pend_q;
  logic                 first_q;  // first cycle out of block reset: REQ merges into auto run
  logic                 start;
  logic                 set_err;

  // Lowest index still pending release; unmasked domains are skipped for free.
  function automatic logic [IDX_W-1:0] lowest(input logic [C_NUM_RST-1:0] v);
    lowest = '0;
    for (int i = C_NUM_RST - 1; i >= 0; i--)
      if (v[i]) lowest = IDX_W'(i);
  endfunction

  assign nxt_idx = lowest(rem_q);
  assign RST_O   = rst_q;
  assign ERR_O   = err_q;
  assign BUSY_O  = !(state_q inside {S_IDLE, S_DONE});
  assign DONE_O  = (state_q == S_DONE);

  // State register; block reset lands in HOLD so the auto sequence starts by itself.
  always_ff @(posedge SYS_CLK_I) begin
    if (SYS_RST_I) state_q <= S_HOLD;
    else           state_q <= state_d;
  end

  // Next-state logic; a finished domain goes to DONE, straight to the next release, or GAP.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    set_err   = 1'b0;
    after_dom = (rem_q == '0) ? S_DONE : ((GAP_L == '0) ? S_RELEASE : S_GAP);
    case (state_q)
      S_IDLE:
        if (REQ_I || pend_q) begin
          start   = 1'b1;
          state_d = (MASK_I == '0) ? S_DONE : S_HOLD;
        end
      S_HOLD:    if (cnt_q <= ONE) state_d = S_RELEASE;
      S_RELEASE: state_d = (TO_L != '0) ? S_WAIT_ACK : after_dom;
      S_WAIT_ACK:
        if (ACK_I[idx_q]) begin
          state_d = after_dom;
        end else if (cnt_q <= ONE) begin
          set_err = 1'b1;
          state_d = after_dom;
        end
      S_GAP:     if (cnt_q <= ONE) state_d = S_RELEASE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath: phase counter, release bookkeeping, error flags and the 1-deep pending request.
  always_ff @(posedge SYS_CLK_I) begin
    if (SYS_RST_I) begin
      cnt_q   <= HOLD_L;
      rem_q   <= '1;
      rst_q   <= '1;
      err_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
      // A request in DONE is kept as pending too, so it is not lost between sequences.
      if (start)
        pend_q <= 1'b0;
      else if (REQ_I && state_q != S_IDLE && !first_q)
        pend_q <= 1'b1;
      if (start) begin
        rem_q <= MASK_I;
        rst_q <= rst_q | MASK_I;
        err_q <= '0;
      end
      if (state_d == S_RELEASE) begin
        idx_q          <= nxt_idx;
        rem_q[nxt_idx] <= 1'b0;
        rst_q[nxt_idx] <= 1'b0;
      end
      if (set_err) err_q[idx_q] <= 1'b1;
      // Reload on phase entry, otherwise count down and stop at zero.
      if (state_d != state_q) begin
        case (state_d)
          S_HOLD:     cnt_q <= HOLD_L;
          S_WAIT_ACK: cnt_q <= TO_L;
          S_GAP:      cnt_q <= GAP_L;
          default:    cnt_q <= cnt_q;
        endcase
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - ONE;
      end
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl. The driver issues requests, resets and ack delays.
// For every sequence it starts, the driver computes the expected release cycles, error
// flags and DONE cycle from the timing rules and queues them. The monitor records
// RST_O edges and compares them against the queue whenever DONE_O pulses.
module tb_rst_seq_ctrl;
  localparam int N     = 4;
  localparam int HOLD  = 50;
  localparam int GAP   = 16;
  localparam int TO    = 1024;
  localparam int NEVER = 100000;

  typedef struct packed {
    logic [31:0]        done;
    logic [N-1:0]       err;
    logic [N-1:0][31:0] rise;
    logic [N-1:0][31:0] fall;
  } exp_t;

  logic         clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic         req = 1'b0;
  logic [N-1:0] mask = '0;
  logic [N-1:0] ack = '0;
  logic [N-1:0] rst_o, err_o;
  logic         busy_o, done_o;

  int   cyc = -1;
  int   n_vec = 0, n_err = 0;
  exp_t exp_q[$];
  int   m_done = 0, m_ignore = -10;
  bit   m_pend = 0;
  int   d_plan[N], d_cur[N], fall_c[N];
  logic [N-1:0] ack_rst_prev = '1;

  rst_seq_ctrl #(.C_NUM_RST(N), .C_HOLD_CLKS(HOLD), .C_GAP_CLKS(GAP),
                 .C_ACK_TIMEOUT(TO), .C_CNT_W(16)) dut (
    .SYS_CLK_I(clk), .SYS_RST_I(sys_rst), .REQ_I(req), .MASK_I(mask), .ACK_I(ack),
    .RST_O(rst_o), .BUSY_O(busy_o), .DONE_O(done_o), .ERR_O(err_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  // Reference timing of one sequence started (REQ sampled in idle) at cycle t.
  task automatic push_seq(input int t, input logic [N-1:0] m, input bit auto_s);
    exp_t e;
    int rel, wend, last_end;
    e = '0;
    for (int i = 0; i < N; i++) begin
      e.rise[i] = '1;
      e.fall[i] = '1;
    end
    rel = t + 1 + HOLD;
    last_end = t;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        e.fall[i] = rel;
        if (!auto_s) e.rise[i] = t + 1;
        if (TO == 0) wend = rel;
        else if (d_cur[i] <= TO) wend = rel + d_cur[i];
        else begin
          wend = rel + TO;
          e.err[i] = 1'b1;
        end
        last_end = wend;
        rel = wend + 1 + GAP;
      end
    end
    e.done = (m == '0) ? t + 1 : last_end + 1;
    m_done = e.done;
    exp_q.push_back(e);
  endtask

  // One clock cycle of stimulus plus the request-level model (idle / busy / pending).
  task automatic tick(input logic r, input logic rs, input logic [N-1:0] mk);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_rst_prev[i] && !rst_o[i]) fall_c[i] = cyc;
      ack[i] = !rst_o[i] && (cyc - fall_c[i] >= d_cur[i]);
    end
    ack_rst_prev = rst_o;
    req = r;
    sys_rst = rs;
    mask = mk;
    if (rs) begin
      exp_q.delete();
      m_pend = 0;
      d_cur = d_plan;
      push_seq(cyc, '1, 1'b1);
      m_ignore = cyc + 1;
    end else if (cyc > m_done && (r || m_pend)) begin
      d_cur = d_plan;
      push_seq(cyc, mk, 1'b0);
      m_pend = 0;
    end else if (r && cyc != m_ignore) begin
      m_pend = 1;
    end
  endtask

  task automatic wait_idle(input logic [N-1:0] mk);
    int n = 0;
    while ((cyc <= m_done || m_pend) && n < 8000) begin
      tick(1'b0, 1'b0, mk);
      n++;
    end
    if (n >= 8000) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: still busy at cyc %0d, required idle", cyc);
    end
  endtask

  task automatic set_d(input int a0, input int a1, input int a2, input int a3);
    d_plan[0] = a0; d_plan[1] = a1; d_plan[2] = a2; d_plan[3] = a3;
  endtask

  // Monitor: reset-state checks, RST_O edge capture, scoreboard compare on DONE_O.
  initial begin
    int rise_rec[N], fall_rec[N];
    logic [N-1:0] prev_o = '1;
    logic rst_prev = 1'b1;
    exp_t e;
    for (int i = 0; i < N; i++) begin rise_rec[i] = -1; fall_rec[i] = -1; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!prev_o[i] && rst_o[i]) rise_rec[i] = cyc;
        if (prev_o[i] && !rst_o[i]) begin
          fall_rec[i] = cyc;
          check("busy_on_release", int'(busy_o), 1);
        end
      end
      prev_o = rst_o;
      if (rst_prev) begin
        check("rst_rst_o", int'(rst_o), int'(4'hF));
        check("rst_busy", int'(busy_o), 1);
        check("rst_done", int'(done_o), 0);
        check("rst_err", int'(err_o), 0);
        for (int i = 0; i < N; i++) begin rise_rec[i] = -1; fall_rec[i] = -1; end
      end else if (done_o) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL done_unexpected @cyc %0d: DONE_O=1, required no pending sequence", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, int'(e.done));
          check("done_busy", int'(busy_o), 0);
          check("err_flags", int'(err_o), int'(e.err));
          for (int i = 0; i < N; i++) begin
            check($sformatf("rise_cyc[%0d]", i), rise_rec[i], int'(e.rise[i]));
            check($sformatf("fall_cyc[%0d]", i), fall_rec[i], int'(e.fall[i]));
          end
        end
        for (int i = 0; i < N; i++) begin rise_rec[i] = -1; fall_rec[i] = -1; end
      end
      rst_prev = sys_rst;
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin fall_c[i] = 0; d_cur[i] = 1; end
    set_d(1, 1, 1, 1);
    // power-on reset, automatic full sequence
    repeat (5) tick(1'b0, 1'b1, '0);
    wait_idle('0);
    // full mask, immediate acks
    tick(1'b1, 1'b0, 4'hF);
    wait_idle('0);
    // sparse mask
    tick(1'b1, 1'b0, 4'b1010);
    wait_idle('0);
    // domain 2 never acks; then a clean run clears ERR
    set_d(1, 1, NEVER, 1);
    tick(1'b1, 1'b0, 4'hF);
    wait_idle('0);
    set_d(1, 1, 1, 1);
    tick(1'b1, 1'b0, 4'hF);
    wait_idle('0);
    // ack exactly at the timeout limit vs one cycle late
    set_d(TO, 2, 3, TO + 1);
    tick(1'b1, 1'b0, 4'b1001);
    wait_idle('0);
    set_d(1, 1, 1, 1);
    // two requests while busy collapse into one extra run; then a zero-mask request
    tick(1'b1, 1'b0, 4'hF);
    repeat (20) tick(1'b0, 1'b0, 4'hF);
    tick(1'b1, 1'b0, 4'hF);
    repeat (10) tick(1'b0, 1'b0, 4'hF);
    tick(1'b1, 1'b0, 4'hF);
    wait_idle(4'b0110);
    tick(1'b1, 1'b0, 4'h0);
    wait_idle('0);
    // block reset during WAIT_ACK, REQ on the first cycle out of reset merges
    set_d(1, NEVER, 1, 1);
    tick(1'b1, 1'b0, 4'hF);
    repeat (100) tick(1'b0, 1'b0, 4'hF);
    set_d(1, 1, 1, 1);
    repeat (3) tick(1'b0, 1'b1, 4'hF);
    tick(1'b1, 1'b0, 4'hF);
    wait_idle('0);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        d_plan[i] = ($urandom_range(0, 15) == 0) ? NEVER : int'($urandom_range(1, 6));
      tick($urandom_range(0, 59) == 0, 1'b0, N'($urandom));
    end
    wait_idle('0);
    repeat (3) tick(1'b0, 1'b0, '0);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
